// File: rtl/demux_memoria.sv
// demux_memoria: selector-routed two-lane FIFO demultiplexer with per-lane valid/ready drain.
// Define DEMUX_MEMORIA_BYPASS_EN to let a word pass straight through an empty lane whose consumer is ready.
module demux_memoria #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    input  logic             selector,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic             valid_out0,
    output logic             valid_out1,
    input  logic             ready_out0,
    input  logic             ready_out1
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0]            r_mem [2][DEPTH];
    logic [1:0][AW-1:0]          r_wr;
    logic [1:0][AW-1:0]          r_rd;
    logic [1:0][CW-1:0]          r_cnt;
    logic [1:0][CW-1:0]          w_cnt_nxt;
    logic [1:0][WIDTH-1:0]       w_dout;
    logic [1:0]                  w_rdy_out;
    logic [1:0]                  w_sel;
    logic [1:0]                  w_empty;
    logic [1:0]                  w_full;
    logic [1:0]                  w_byp;
    logic [1:0]                  w_push;
    logic [1:0]                  w_pop;
    logic [1:0]                  w_vout;

    assign w_rdy_out = {ready_out1, ready_out0};

    always_comb begin
        for (int x = 0; x < 2; x++) begin
            w_empty[x]   = r_cnt[x] == '0;
            w_full[x]    = r_cnt[x] == CW'(DEPTH);
            w_sel[x]     = valid_in && (selector == x[0]);
`ifdef DEMUX_MEMORIA_BYPASS_EN
            w_byp[x]     = w_sel[x] && w_empty[x] && w_rdy_out[x];
`else
            w_byp[x]     = 1'b0;
`endif
            // A full lane refuses pushes even when it pops this cycle.
            w_push[x]    = w_sel[x] && !w_full[x] && !w_byp[x];
            w_pop[x]     = !w_empty[x] && w_rdy_out[x];
            w_vout[x]    = !w_empty[x] || w_byp[x];
            w_dout[x]    = w_byp[x] ? data_in : (w_empty[x] ? '0 : r_mem[x][r_rd[x]]);
            w_cnt_nxt[x] = r_cnt[x] + CW'(w_push[x]) - CW'(w_pop[x]);
        end
    end

    assign ready_in   = selector ? !w_full[1] : !w_full[0];
    assign valid_out0 = w_vout[0];
    assign valid_out1 = w_vout[1];
    assign data_out0  = w_dout[0];
    assign data_out1  = w_dout[1];

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int x = 0; x < 2; x++)
                for (int i = 0; i < DEPTH; i++)
                    r_mem[x][i] <= '0;
        end else begin
            for (int x = 0; x < 2; x++) begin
                if (w_push[x]) begin
                    r_mem[x][r_wr[x]] <= data_in;
                    r_wr[x]           <= r_wr[x] + 1'b1;
                end
                if (w_pop[x])
                    r_rd[x] <= r_rd[x] + 1'b1;
                r_cnt[x] <= w_cnt_nxt[x];
            end
        end
    end
endmodule

// File: doc/demux_memoria.md
# demux_memoria

Two-lane buffered demultiplexer, the write-side counterpart of the 2:1 mux with memory. One WIDTH-bit input stream is routed by `selector` into one of two per-lane FIFOs; each lane drains to its consumer through its own valid/ready handshake. It sits between a single producer and two consumers that share the 2-bit data format used by the mux with memory.

## Interface
- WIDTH, 2, data word width in bits
- DEPTH, 2, entries per lane FIFO; power of two, ≥2
- clk  input  1  rising-edge clock for all state
- reset_L  input  1  synchronous, active-low reset; sampled on rising edge of clk
- data_in  input  WIDTH  input word
- valid_in  input  1  data_in is valid this cycle
- selector  input  1  target lane for data_in: 0 → lane 0, 1 → lane 1
- ready_in  output  1  target lane can accept this cycle
- data_out0 / data_out1  output  WIDTH  head word of lane 0 / lane 1
- valid_out0 / valid_out1  output  1  lane head is valid
- ready_out0 / ready_out1  input  1  consumer takes head of lane 0 / lane 1

## Operation
- Reset (reset_L=0 at posedge):
  - Both lanes go EMPTY.
  - Pointers and counts are cleared; FIFO storage is cleared to 0.
  - valid_out0 = valid_out1 = 0; data_out0 = data_out1 = 0.
  - Reset wins over any simultaneous push or pop; in-flight contents are discarded.
- Per-lane state machine, encoded by count (width $clog2(DEPTH)+1):
  - EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
  - Push only: count+1. Pop only: count−1. Push and pop together: count unchanged.
  - Transitions: EMPTY→PARTIAL on push; PARTIAL→FULL on push at count=DEPTH−1; FULL→PARTIAL on pop; PARTIAL→EMPTY on pop at count=1.
- ready_in = selector ? (lane1 != FULL) : (lane0 != FULL). Combinational.
- A push occurs when valid_in && ready_in. The word is written to the selected lane at its write pointer.
- A full lane never accepts a push, even if it pops in the same cycle. There is no full pass-through.
- A pop on lane X occurs when valid_outX && ready_outX. The lane's read pointer advances.
- Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- valid_outX = (laneX != EMPTY). data_outX = storage[rd_ptrX] when valid_outX is high, otherwise 0.
- The two lanes are independent. Lane 1 can pop while lane 0 is pushed in the same cycle.
- Word order within each lane is preserved. There is no ordering relation between lanes.
- valid_in=0 means no push, regardless of selector.

## Timing
- Default build: push at edge N → valid_outX=1 and the word on data_outX from just after edge N. Latency is 1 cycle.
- ready_in depends combinationally on selector and registered lane state only; there is no path from valid_in.
- valid_outX and data_outX are driven from registered state only.
- Throughput: one push per cycle, plus one pop per lane per cycle.
- After reset is released, the first push is accepted in the same cycle reset_L samples 1 if valid_in is high.

## Configuration
- DEMUX_MEMORIA_BYPASS_EN defined:
  - When the target lane is EMPTY, valid_in=1, and ready_outX=1, the word passes straight through in the same cycle.
  - Pass-through drives data_outX = data_in and valid_outX = 1 combinationally.
  - The word is consumed without being stored; count stays 0 and pointers do not move.
  - Otherwise behaviour is identical to the default build.
  - This adds combinational paths valid_in/data_in/selector → valid_outX/data_outX.
- Undefined: no bypass; minimum latency 1 cycle; all outputs registered as in Timing.

## Test plan
- Reset then idle: hold reset_L=0 for 2 cycles with valid_in=1, data_in=2'b11 → valid_out0/1=0, data_out0/1=2'b00, ready_in=1 after reset.
- Routing: push 2'b01 (sel 0), 2'b10 (sel 1), 2'b11 (sel 0), with ready_out0/1=0 → lane0 head 2'b01, lane1 head 2'b10. Then raise ready_out0 → lane0 emits 01, then 11, then valid_out0=0.
- Full boundary (DEPTH=2): push 2'b01 and 2'b10 to lane 0 with ready_out0=0 → ready_in=0 while selector=0, and a third valid push is not accepted. With selector=1, ready_in=1.
- Full with simultaneous pop: lane0 FULL, ready_out0=1, valid_in=1, selector=0 → pop occurs, no push, count=1. Next cycle ready_in=1.
- Wrap-around: stream 2'b00,01,10,11,00,01 through lane 1 with ready_out1=1 → identical sequence emitted in order, one cycle delayed (zero delay with DEMUX_MEMORIA_BYPASS_EN).
- Reset mid-operation: lane0 holds 2 words and lane1 holds 1; assert reset_L=0 for one edge → all valid_out=0, data_out=0; subsequent pushes are emitted correctly.
